// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// per-lane valid bits and synchronous flush. in_ready decodes registered state only.
//
// state   | meaning
// --------+--------------------------------------------------
// S_EMPTY | no beat held, out_valid=0, in_ready=1
// S_ONE   | main entry drives out_*, skid empty, in_ready=1
// S_FULL  | main drives out_*, skid holds overflow, in_ready=0
module pipe_stage_skid #(
  parameter int WIDTH        = 128,
  parameter int LANES        = 2,
  parameter int ZERO_INVALID = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES-1:0]       in_lane_vld,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_lane_vld,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [1:0]             occupancy
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam bit         ZI      = (ZERO_INVALID != 0);

  logic [1:0]             state_q, state_d;
  logic [LANES*WIDTH-1:0] main_data_q, main_data_d;
  logic [LANES-1:0]       main_vld_q, main_vld_d;
  logic [LANES*WIDTH-1:0] skid_data_q, skid_data_d;
  logic [LANES-1:0]       skid_vld_q, skid_vld_d;
  logic [LANES*WIDTH-1:0] in_masked;
  logic                   accept;
  logic                   pop;

  assign in_ready     = (state_q != S_FULL);
  assign out_valid    = (state_q != S_EMPTY);
  assign occupancy    = state_q;
  assign out_data     = main_data_q;
  assign out_lane_vld = main_vld_q;
  assign accept       = in_valid & in_ready;
  assign pop          = out_valid & out_ready;

  // Invalid lanes are stored as zero so stale fields never leak downstream.
  always_comb begin
    in_masked = in_data;
    for (int i = 0; i < LANES; i++) begin
      if (ZI && !in_lane_vld[i]) in_masked[i*WIDTH +: WIDTH] = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_vld_d  = main_vld_q;
    skid_data_d = skid_data_q;
    skid_vld_d  = skid_vld_q;
    if (flush) begin
      // A beat popped this cycle is already delivered; everything else dies.
      state_d    = S_EMPTY;
      main_vld_d = '0;
      skid_vld_d = '0;
      if (ZI) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d     = S_ONE;
            main_data_d = in_masked;
            main_vld_d  = in_lane_vld;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            main_data_d = in_masked;
            main_vld_d  = in_lane_vld;
          end else if (accept) begin
            state_d     = S_FULL;
            skid_data_d = in_masked;
            skid_vld_d  = in_lane_vld;
          end else if (pop) begin
            state_d    = S_EMPTY;
            main_vld_d = '0;
            if (ZI) main_data_d = '0;
          end
        end
        S_FULL: begin
          if (pop) begin
            state_d     = S_ONE;
            main_data_d = skid_data_q;
            main_vld_d  = skid_vld_q;
            skid_vld_d  = '0;
            if (ZI) skid_data_d = '0;
          end
        end
        default: begin
          state_d    = S_EMPTY;
          main_vld_d = '0;
          skid_vld_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_vld_q  <= '0;
      skid_data_q <= '0;
      skid_vld_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_vld_q  <= main_vld_d;
      skid_data_q <= skid_data_d;
      skid_vld_q  <= skid_vld_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one zeroing instance and one stale-payload
// instance share all inputs; expected values are hand-computed per vector.
module tb_pipe_stage_skid;

  localparam int W = 16;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [L-1:0] in_lane_vld;
  logic [L*W-1:0] in_data;
  logic         out_ready;

  logic           in_ready, out_valid;
  logic [L-1:0]   out_lane_vld;
  logic [L*W-1:0] out_data;
  logic [1:0]     occupancy;

  logic           nz_in_ready, nz_out_valid;
  logic [L-1:0]   nz_out_lane_vld;
  logic [L*W-1:0] nz_out_data;
  logic [1:0]     nz_occupancy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(W), .LANES(L), .ZERO_INVALID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane_vld(in_lane_vld), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_vld(out_lane_vld),
    .out_data(out_data), .occupancy(occupancy)
  );

  pipe_stage_skid #(.WIDTH(W), .LANES(L), .ZERO_INVALID(0)) dut_nz (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(nz_in_ready), .in_lane_vld(in_lane_vld), .in_data(in_data),
    .out_valid(nz_out_valid), .out_ready(out_ready), .out_lane_vld(nz_out_lane_vld),
    .out_data(nz_out_data), .occupancy(nz_occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [W-1:0] l0, input logic [W-1:0] l1, input logic [L-1:0] vld);
    in_valid    = 1'b1;
    in_data     = {l1, l0};
    in_lane_vld = vld;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_lane_vld = '0; in_data = '0; out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_occ",   32'(occupancy), 32'd0);
    chk("rst_ovld",  32'(out_valid), 32'd0);
    chk("rst_irdy",  32'(in_ready), 32'd1);
    chk("rst_lvld",  32'(out_lane_vld), 32'd0);
    chk("rst_data",  out_data, 32'd0);
    step();
    rst = 1'b1;

    // Streaming at full rate
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      offer(W'(k), W'(k + 16'h100), 2'b11);
      step();
      chk("strm_l0",   32'(out_data[W-1:0]), 32'(k));
      chk("strm_occ",  32'(occupancy), 32'd1);
      chk("strm_irdy", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("strm_drain_ovld", 32'(out_valid), 32'd0);
    chk("strm_drain_data", out_data, 32'd0);

    // Back-pressure: A held, B in skid, C refused
    out_ready = 1'b0;
    offer(16'hA, 16'h0, 2'b01);
    step();
    chk("bp_a_out", out_data, 32'hA);
    chk("bp_a_occ", 32'(occupancy), 32'd1);
    offer(16'hB, 16'h0, 2'b01);
    step();
    chk("bp_b_occ",  32'(occupancy), 32'd2);
    chk("bp_b_irdy", 32'(in_ready), 32'd0);
    chk("bp_b_out",  out_data, 32'hA);
    offer(16'hC, 16'h0, 2'b01);
    step();
    chk("bp_c_occ", 32'(occupancy), 32'd2);
    chk("bp_c_out", out_data, 32'hA);
    out_ready = 1'b1;
    step();
    chk("bp_rel_b",    out_data, 32'hB);
    chk("bp_rel_irdy", 32'(in_ready), 32'd1);
    chk("bp_rel_occ",  32'(occupancy), 32'd1);
    step();
    chk("bp_rel_c",    out_data, 32'hC);
    chk("bp_rel_cv",   32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 32'(occupancy), 32'd0);

    // Flush while FULL
    out_ready = 1'b0;
    offer(16'h11, 16'h22, 2'b11);
    step();
    offer(16'h33, 16'h44, 2'b11);
    step();
    chk("fl_full", 32'(occupancy), 32'd2);
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_occ",  32'(occupancy), 32'd0);
    chk("fl_ovld", 32'(out_valid), 32'd0);
    chk("fl_lvld", 32'(out_lane_vld), 32'd0);
    chk("fl_data", out_data, 32'd0);
    chk("fl_irdy", 32'(in_ready), 32'd1);
    chk("fl_nz_lvld", 32'(nz_out_lane_vld), 32'd0);

    // Flush with a simultaneous accept of D
    offer(16'hD, 16'hD, 2'b11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_d_occ", 32'(occupancy), 32'd0);
    step();
    chk("fl_d_ovld", 32'(out_valid), 32'd0);
    chk("fl_d_data", out_data, 32'd0);

    // Lane zeroing vs stale payload
    offer(16'h1234, 16'hDEAD, 2'b01);
    step();
    in_valid = 1'b0;
    chk("lz_lvld",    32'(out_lane_vld), 32'b01);
    chk("lz_l0",      32'(out_data[W-1:0]), 32'h1234);
    chk("lz_l1_zero", 32'(out_data[2*W-1:W]), 32'h0);
    chk("lz_nz_l1",   32'(nz_out_data[2*W-1:W]), 32'hDEAD);
    chk("lz_nz_lvld", 32'(nz_out_lane_vld), 32'b01);

    // Empty-lane beat still occupies an entry
    offer(16'h5, 16'h6, 2'b00);
    step();
    in_valid = 1'b0;
    chk("nolane_occ",  32'(occupancy), 32'd2);
    out_ready = 1'b1;
    step();
    chk("nolane_lvld", 32'(out_lane_vld), 32'd0);
    chk("nolane_data", out_data, 32'd0);
    chk("nolane_occ1", 32'(occupancy), 32'd1);
    step();
    chk("nolane_empty", 32'(occupancy), 32'd0);

    // Async reset mid-transfer, between edges
    out_ready = 1'b0;
    offer(16'h77, 16'h0, 2'b01);
    step();
    offer(16'h88, 16'h0, 2'b01);
    step();
    in_valid = 1'b0;
    chk("ar_full", 32'(occupancy), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("ar_occ",  32'(occupancy), 32'd0);
    chk("ar_ovld", 32'(out_valid), 32'd0);
    chk("ar_data", out_data, 32'd0);
    chk("ar_lvld", 32'(out_lane_vld), 32'd0);
    chk("ar_irdy", 32'(in_ready), 32'd1);
    rst = 1'b1;
    out_ready = 1'b1;
    offer(16'hF, 16'h0, 2'b01);
    step();
    chk("ar_first", out_data, 32'hF);
    chk("ar_first_occ", 32'(occupancy), 32'd1);

    // Pop during flush: E is delivered, then nothing remains
    offer(16'hE, 16'h0, 2'b01);
    step();
    in_valid = 1'b0;
    chk("pf_e_out", out_data, 32'hE);
    flush = 1'b1;
    #1;
    chk("pf_e_pop", 32'(out_valid & out_ready), 32'd1);
    step();
    flush = 1'b0;
    chk("pf_ovld", 32'(out_valid), 32'd0);
    chk("pf_occ",  32'(occupancy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, per-lane valid bits and a synchronous flush. It replaces the fixed stall/flush stage registers (IF/ID through MEM/WB) of the dual-issue core: one instance per stage boundary, with all stage fields packed into one payload lane per issue slot. Back-pressure is registered, so ready never has a combinational path from output to input.

## Interface
- `WIDTH`, default 128: payload bits per lane (packed stage fields).
- `LANES`, default 2: issue slots carried per beat.
- `ZERO_INVALID`, default 1: 1 = payload of invalid lanes and empty entries is forced to zero; 0 = stale payload is retained.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of every held beat.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept; registered (depends on state only).
- `in_lane_vld`  in  LANES  per-lane valid of the incoming beat.
- `in_data`  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- `out_valid`  out  1  beat present at output.
- `out_ready`  in  1  downstream accepts.
- `out_lane_vld`  out  LANES  per-lane valid of the output beat.
- `out_data`  out  LANES*WIDTH  output payload, same packing.
- `occupancy`  out  2  held beats: 0, 1 or 2.

## Operation
- Storage: the main entry drives `out_*`; the skid entry holds one overflow beat. Each entry holds LANES*WIDTH payload bits plus a LANES-bit lane-valid field.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- States, encoded as occupancy:
  - EMPTY (0): accept -> ONE, main <= in.
  - ONE (1):
    - accept & pop -> ONE, main <= in.
    - accept & !pop -> FULL, skid <= in.
    - !accept & pop -> EMPTY.
    - otherwise hold.
  - FULL (2): pop -> ONE, main <= skid. No accept is possible because in_ready=0.
- Output signals: out_valid = (occupancy != 0); in_ready = (occupancy != 2). Both decode registered state only.
- Lane handling:
  - A beat with in_lane_vld all zero is still a beat. It is accepted and occupies an entry.
  - With ZERO_INVALID=1, lane i payload is stored as zero when in_lane_vld[i]=0.
- Empty main entry: out_lane_vld = 0. out_data = 0 if ZERO_INVALID=1, otherwise last value.
- Flush (priority over every other event):
  - Next state is EMPTY; both entries' lane-valid fields are cleared.
  - With ZERO_INVALID=1, both payloads are zeroed.
  - A beat accepted in the flush cycle is consumed upstream and discarded.
  - A beat popped in the flush cycle is delivered, since the handshake completed. Flush kills only beats that would remain held after the edge.
- Stall equivalent: out_ready=0 holds the output beat stable. Upstream may still land one beat in the skid entry, then in_ready drops.
- Reset (rst=0, any time, including mid-transfer): occupancy=0, in_ready=1 after release, out_valid=0, out_lane_vld=0, out_data=0, skid cleared. Takes effect immediately, without waiting for a clock edge.

## Timing
- Latency: a beat accepted at edge N is on out_* after edge N (visible in cycle N+1). No combinational in->out path.
- Throughput: one beat per cycle while out_ready=1.
- in_ready falls the cycle after the skid entry fills. It rises the cycle after a pop from FULL.
- When FULL, a pop and a refill of main from skid happen at the same edge. The next beat appears without a bubble.
- occupancy updates on the same edge as the entries.
- Reset assertion is asynchronous. Release is sampled at the next rising edge and must be synchronised externally.

## Test plan
- Stream: out_ready=1; beats 0x1..0x8 on lane 0, in_lane_vld=2'b11 every cycle -> out_data lane 0 = 0x1..0x8 in consecutive cycles, one cycle after each accept; occupancy stays 1; in_ready stays 1.
- Back-pressure:
  - out_ready=0 while beats A,B,C are offered -> A held on output, B in skid, occupancy=2, in_ready=0 from the cycle after B is accepted, C not accepted.
  - Then out_ready=1 -> A, B, C delivered back-to-back with no bubble and no loss.
- Flush in FULL, out_ready=0, flush=1 for one cycle -> next cycle occupancy=0, out_valid=0, out_lane_vld=0, out_data=0, in_ready=1. Flush with a simultaneous accept of D -> D never appears at the output.
- Lane zeroing, ZERO_INVALID=1: beat with in_lane_vld=2'b01 and lane 1 payload 0xDEAD -> out_lane_vld=2'b01, lane 1 out_data=0. With ZERO_INVALID=0, lane 1 out_data=0xDEAD.
- Async reset mid-transfer: drop rst while FULL, between clock edges -> outputs clear immediately, without a clock edge. After release, the first accepted beat appears after one edge.
- Pop during flush: occupancy=1 with beat E, out_ready=1, flush=1 -> E counted as delivered in that cycle; next cycle out_valid=0.
